// File: rtl/pong_engine.sv
// pong_engine: frame-stepped Pong core owning ball, paddles, scoring and serve/play/over sequencing.
// Optional build macro SHADY_PONG_AI_EN makes the right paddle track the ball instead of btns[3:2].

module pong_engine #(
   parameter int unsigned H_RES         = 640,
   parameter int unsigned V_RES         = 480,
   parameter int unsigned PADDLE_H      = 64,
   parameter int unsigned PADDLE_W      = 8,
   parameter int unsigned PADDLE_MARGIN = 16,
   parameter int unsigned BALL_SIZE     = 8,
   parameter int unsigned SPD_W         = 4,
   parameter int unsigned SCORE_W       = 4,
   parameter int unsigned WIN_SCORE     = 9,
   parameter int unsigned SERVE_FRAMES  = 60
) (
   input  logic                       CLK,
   input  logic                       rst,
   input  logic                       frame_tick,
   input  logic [3:0]                 btns,
   input  logic [SPD_W-1:0]           ball_speed,
   input  logic [SPD_W-1:0]           player_speed,
   output logic [$clog2(H_RES)-1:0]   ball_x,
   output logic [$clog2(V_RES)-1:0]   ball_y,
   output logic [$clog2(V_RES)-1:0]   paddle1_y,
   output logic [$clog2(V_RES)-1:0]   paddle2_y,
   output logic [SCORE_W-1:0]         score1,
   output logic [SCORE_W-1:0]         score2,
   output logic [1:0]                 state,
   output logic                       game_over
);

   localparam int unsigned XW = $clog2(H_RES);
   localparam int unsigned YW = $clog2(V_RES);
   localparam int unsigned CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

   localparam logic [XW-1:0] BALL_X0 = XW'((H_RES - BALL_SIZE) / 2);
   localparam logic [YW-1:0] BALL_Y0 = YW'((V_RES - BALL_SIZE) / 2);
   localparam logic [YW-1:0] PAD_Y0  = YW'((V_RES - PADDLE_H) / 2);
   localparam logic [YW-1:0] PAD_MAX = YW'(V_RES - PADDLE_H);
   localparam logic [YW-1:0] Y_MAX   = YW'(V_RES - BALL_SIZE);
   localparam logic [XW-1:0] L_FACE  = XW'(PADDLE_MARGIN + PADDLE_W);
   localparam logic [XW-1:0] R_FACE  = XW'(H_RES - PADDLE_MARGIN - PADDLE_W - BALL_SIZE);

   localparam logic signed [XW+1:0] L_FACE_S = (XW+2)'(PADDLE_MARGIN + PADDLE_W);
   localparam logic signed [XW+1:0] R_FACE_S =
      (XW+2)'(H_RES - PADDLE_MARGIN - PADDLE_W - BALL_SIZE);
   localparam logic signed [XW+1:0] X_MAX_S  = (XW+2)'(H_RES - BALL_SIZE);
   localparam logic signed [YW+1:0] Y_MAX_S  = (YW+2)'(V_RES - BALL_SIZE);

   localparam logic [CW-1:0]      SERVE_LAST = CW'(SERVE_FRAMES - 1);
   localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

   typedef enum logic [1:0] {
      StServe = 2'd0,
      StPlay  = 2'd1,
      StPoint = 2'd2,
      StOver  = 2'd3
   } state_e;

   state_e          state_q;
   logic [CW-1:0]   serve_cnt_q;
   logic            dx_q;          // 1 = moving right
   logic            dy_q;          // 1 = moving down
   logic            p1_scored_q;

   logic signed [XW+1:0] nx;
   logic signed [YW+1:0] ny;
   logic [YW-1:0]        y_play;
   logic                 dy_play;
   logic                 ov1, ov2;
   logic                 hit_l, hit_r, miss_l, miss_r;
   logic [YW-1:0]        p1_next, p2_next;
   logic [SCORE_W-1:0]   score1_inc, score2_inc;

   // Saturating manual paddle step; both or neither button holds.
   function automatic logic [YW-1:0] pad_step(input logic [YW-1:0]    y,
                                             input logic             up,
                                             input logic             dn,
                                             input logic [SPD_W-1:0] spd);
      logic [YW:0] sum;
      sum = {1'b0, y} + (YW+1)'(spd);
      if (up && !dn) begin
         return ({1'b0, y} >= (YW+1)'(spd)) ? (y - YW'(spd)) : '0;
      end
      if (dn && !up) begin
         return (sum > {1'b0, PAD_MAX}) ? PAD_MAX : sum[YW-1:0];
      end
      return y;
   endfunction

`ifdef SHADY_PONG_AI_EN
   // Step the paddle centre toward the ball centre by at most spd.
   function automatic logic [YW-1:0] ai_step(input logic [YW-1:0]    y,
                                            input logic [YW-1:0]    by,
                                            input logic [SPD_W-1:0] spd);
      logic [YW:0] target;
      logic [YW:0] centre;
      logic [YW:0] err;
      logic [YW:0] step;
      target = {1'b0, by} + (YW+1)'(BALL_SIZE / 2);
      centre = {1'b0, y} + (YW+1)'(PADDLE_H / 2);
      err    = (target > centre) ? (target - centre) : (centre - target);
      step   = (err < (YW+1)'(spd)) ? err : (YW+1)'(spd);
      if (target > centre) begin
         return pad_step(y, 1'b0, 1'b1, SPD_W'(step));
      end
      return pad_step(y, 1'b1, 1'b0, SPD_W'(step));
   endfunction
`endif

   always_comb begin
      nx = dx_q ? ($signed({2'b00, ball_x}) + $signed((XW+2)'(ball_speed)))
                : ($signed({2'b00, ball_x}) - $signed((XW+2)'(ball_speed)));
      ny = dy_q ? ($signed({2'b00, ball_y}) + $signed((YW+2)'(ball_speed)))
                : ($signed({2'b00, ball_y}) - $signed((YW+2)'(ball_speed)));

      y_play  = ny[YW-1:0];
      dy_play = dy_q;
      if (dy_q && (ny >= Y_MAX_S)) begin
         y_play  = Y_MAX;
         dy_play = 1'b0;
      end else if (!dy_q && ny[YW+1]) begin
         y_play  = '0;
         dy_play = 1'b1;
      end

      // Overlap uses pre-move ball and paddle positions.
      ov1 = (({1'b0, ball_y} + (YW+1)'(BALL_SIZE)) > {1'b0, paddle1_y}) &&
            ({1'b0, ball_y} < ({1'b0, paddle1_y} + (YW+1)'(PADDLE_H)));
      ov2 = (({1'b0, ball_y} + (YW+1)'(BALL_SIZE)) > {1'b0, paddle2_y}) &&
            ({1'b0, ball_y} < ({1'b0, paddle2_y} + (YW+1)'(PADDLE_H)));

      hit_l  = !dx_q && (nx <= L_FACE_S) && (ball_x >= L_FACE) && ov1;
      hit_r  = dx_q && (nx >= R_FACE_S) && (ball_x <= R_FACE) && ov2;
      miss_l = !dx_q && nx[XW+1];
      miss_r = dx_q && (nx > X_MAX_S);

      p1_next = pad_step(paddle1_y, btns[0], btns[1], player_speed);
`ifdef SHADY_PONG_AI_EN
      p2_next = ai_step(paddle2_y, ball_y, player_speed);
`else
      p2_next = pad_step(paddle2_y, btns[2], btns[3], player_speed);
`endif

      score1_inc = score1 + SCORE_W'(1);
      score2_inc = score2 + SCORE_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q     <= StServe;
         serve_cnt_q <= '0;
         dx_q        <= 1'b1;
         dy_q        <= 1'b1;
         p1_scored_q <= 1'b0;
         ball_x      <= BALL_X0;
         ball_y      <= BALL_Y0;
         paddle1_y   <= PAD_Y0;
         paddle2_y   <= PAD_Y0;
         score1      <= '0;
         score2      <= '0;
         game_over   <= 1'b0;
      end else if (frame_tick) begin
         unique case (state_q)
            StServe: begin
               paddle1_y <= p1_next;
               paddle2_y <= p2_next;
               ball_x    <= BALL_X0;
               ball_y    <= BALL_Y0;
               if (serve_cnt_q == SERVE_LAST) begin
                  state_q     <= StPlay;
                  serve_cnt_q <= '0;
               end else begin
                  serve_cnt_q <= serve_cnt_q + CW'(1);
               end
            end
            StPlay: begin
               paddle1_y <= p1_next;
               paddle2_y <= p2_next;
               // A stationary ball never triggers walls, paddles or misses.
               if (ball_speed != '0) begin
                  ball_y <= y_play;
                  dy_q   <= dy_play;
                  if (hit_l) begin
                     ball_x <= L_FACE;
                     dx_q   <= 1'b1;
                  end else if (hit_r) begin
                     ball_x <= R_FACE;
                     dx_q   <= 1'b0;
                  end else if (miss_l) begin
                     state_q     <= StPoint;
                     p1_scored_q <= 1'b0;
                  end else if (miss_r) begin
                     state_q     <= StPoint;
                     p1_scored_q <= 1'b1;
                  end else begin
                     ball_x <= nx[XW-1:0];
                  end
               end
            end
            StPoint: begin
               paddle1_y   <= p1_next;
               paddle2_y   <= p2_next;
               ball_x      <= BALL_X0;
               ball_y      <= BALL_Y0;
               serve_cnt_q <= '0;
               // Next serve heads toward whoever conceded.
               dx_q        <= p1_scored_q;
               if (p1_scored_q) begin
                  score1 <= score1_inc;
                  if (score1_inc == WIN) begin
                     state_q   <= StOver;
                     game_over <= 1'b1;
                  end else begin
                     state_q <= StServe;
                  end
               end else begin
                  score2 <= score2_inc;
                  if (score2_inc == WIN) begin
                     state_q   <= StOver;
                     game_over <= 1'b1;
                  end else begin
                     state_q <= StServe;
                  end
               end
            end
            StOver: begin
               if (|btns) begin
                  state_q     <= StServe;
                  game_over   <= 1'b0;
                  score1      <= '0;
                  score2      <= '0;
                  paddle1_y   <= PAD_Y0;
                  paddle2_y   <= PAD_Y0;
                  ball_x      <= BALL_X0;
                  ball_y      <= BALL_Y0;
                  serve_cnt_q <= '0;
               end
            end
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: directed, hand-computed scenarios for pong_engine in its default build.

module tb_pong_engine;

   logic       CLK = 1'b0;
   logic       rst;
   logic       frame_tick;
   logic [3:0] btns;
   logic [3:0] ball_speed;
   logic [3:0] player_speed;
   logic [9:0] ball_x;
   logic [8:0] ball_y;
   logic [8:0] paddle1_y;
   logic [8:0] paddle2_y;
   logic [3:0] score1;
   logic [3:0] score2;
   logic [1:0] state;
   logic       game_over;

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   pong_engine dut (
      .CLK          (CLK),
      .rst          (rst),
      .frame_tick   (frame_tick),
      .btns         (btns),
      .ball_speed   (ball_speed),
      .player_speed (player_speed),
      .ball_x       (ball_x),
      .ball_y       (ball_y),
      .paddle1_y    (paddle1_y),
      .paddle2_y    (paddle2_y),
      .score1       (score1),
      .score2       (score2),
      .state        (state),
      .game_over    (game_over)
   );

   // Called at a falling edge; each iteration spans one rising edge with frame_tick high.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         @(negedge CLK);
         frame_tick = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      frame_tick = 1'b0;
      @(negedge CLK);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge CLK);
      do_reset();
      checks++;
      if (ball_x !== 10'd316 || ball_y !== 9'd236) begin
         failures++;
         $display("FAIL reset_ball got=(%0d,%0d) want=(316,236)", ball_x, ball_y);
      end
      checks++;
      if (paddle1_y !== 9'd208 || paddle2_y !== 9'd208) begin
         failures++;
         $display("FAIL reset_paddles got=(%0d,%0d) want=(208,208)", paddle1_y, paddle2_y);
      end
      checks++;
      if (score1 !== 4'd0 || score2 !== 4'd0 || state !== 2'd0 || game_over !== 1'b0) begin
         failures++;
         $display("FAIL reset_status got=s1 %0d s2 %0d st %0d go %0d want=0 0 0 0",
                  score1, score2, state, game_over);
      end
   endtask

   task automatic test_serve();
      for (int i = 1; i <= 59; i++) begin
         tick(1);
         checks++;
         if (state !== 2'd0 || ball_x !== 10'd316 || ball_y !== 9'd236) begin
            failures++;
            $display("FAIL serve_hold tick=%0d got=st %0d (%0d,%0d) want=st 0 (316,236)",
                     i, state, ball_x, ball_y);
         end
      end
      tick(1);
      checks++;
      if (state !== 2'd1 || ball_x !== 10'd316 || ball_y !== 9'd236) begin
         failures++;
         $display("FAIL serve_to_play got=st %0d (%0d,%0d) want=st 1 (316,236)",
                  state, ball_x, ball_y);
      end
   endtask

   task automatic test_wall_bounce();
      ball_speed = 4'd8;
      repeat (5) @(negedge CLK);
      checks++;
      if (ball_x !== 10'd316 || ball_y !== 9'd236) begin
         failures++;
         $display("FAIL hold_no_tick got=(%0d,%0d) want=(316,236)", ball_x, ball_y);
      end
      tick(29);
      checks++;
      if (ball_x !== 10'd548 || ball_y !== 9'd468) begin
         failures++;
         $display("FAIL diag_move got=(%0d,%0d) want=(548,468)", ball_x, ball_y);
      end
      ball_speed = 4'd4;
      tick(1);
      checks++;
      if (ball_x !== 10'd552 || ball_y !== 9'd472) begin
         failures++;
         $display("FAIL bottom_clamp got=(%0d,%0d) want=(552,472)", ball_x, ball_y);
      end
      tick(1);
      checks++;
      if (ball_x !== 10'd556 || ball_y !== 9'd468) begin
         failures++;
         $display("FAIL bottom_bounce got=(%0d,%0d) want=(556,468)", ball_x, ball_y);
      end
   endtask

   task automatic test_right_paddle();
      ball_speed   = 4'd0;
      btns         = 4'b1000;
      player_speed = 4'd15;
      tick(14);
      checks++;
      if (paddle2_y !== 9'd416 || ball_x !== 10'd556 || ball_y !== 9'd468) begin
         failures++;
         $display("FAIL p2_down_sat got=p2 %0d (%0d,%0d) want=p2 416 (556,468)",
                  paddle2_y, ball_x, ball_y);
      end
      btns       = 4'b0000;
      ball_speed = 4'd4;
      tick(12);
      checks++;
      if (ball_x !== 10'd604 || ball_y !== 9'd420) begin
         failures++;
         $display("FAIL approach_right got=(%0d,%0d) want=(604,420)", ball_x, ball_y);
      end
      tick(1);
      checks++;
      if (ball_x !== 10'd608 || ball_y !== 9'd416 || state !== 2'd1) begin
         failures++;
         $display("FAIL right_hit got=(%0d,%0d) st %0d want=(608,416) st 1",
                  ball_x, ball_y, state);
      end
      tick(1);
      checks++;
      if (ball_x !== 10'd604 || ball_y !== 9'd412) begin
         failures++;
         $display("FAIL right_rebound got=(%0d,%0d) want=(604,412)", ball_x, ball_y);
      end
   endtask

   task automatic test_left_paddle();
      ball_speed = 4'd8;
      tick(72);
      checks++;
      if (ball_x !== 10'd28 || ball_y !== 9'd160) begin
         failures++;
         $display("FAIL top_wall_path got=(%0d,%0d) want=(28,160)", ball_x, ball_y);
      end
      ball_speed   = 4'd0;
      btns         = 4'b0001;
      player_speed = 4'd4;
      tick(17);
      checks++;
      if (paddle1_y !== 9'd140) begin
         failures++;
         $display("FAIL p1_up got=%0d want=140", paddle1_y);
      end
      btns       = 4'b0000;
      ball_speed = 4'd4;
      tick(1);
      checks++;
      if (ball_x !== 10'd24 || ball_y !== 9'd164 || score1 !== 4'd0 || score2 !== 4'd0) begin
         failures++;
         $display("FAIL left_hit got=(%0d,%0d) s %0d-%0d want=(24,164) s 0-0",
                  ball_x, ball_y, score1, score2);
      end
      tick(1);
      checks++;
      if (ball_x !== 10'd28 || ball_y !== 9'd168) begin
         failures++;
         $display("FAIL left_rebound got=(%0d,%0d) want=(28,168)", ball_x, ball_y);
      end
   endtask

   task automatic test_left_miss();
      ball_speed = 4'd8;
      tick(38);
      checks++;
      if (ball_x !== 10'd332 || ball_y !== 9'd472) begin
         failures++;
         $display("FAIL cross_right got=(%0d,%0d) want=(332,472)", ball_x, ball_y);
      end
      ball_speed   = 4'd0;
      btns         = 4'b0100;
      player_speed = 4'd15;
      tick(16);
      checks++;
      if (paddle2_y !== 9'd176) begin
         failures++;
         $display("FAIL p2_up got=%0d want=176", paddle2_y);
      end
      btns       = 4'b0000;
      ball_speed = 4'd8;
      tick(35);
      checks++;
      if (ball_x !== 10'd608 || ball_y !== 9'd192) begin
         failures++;
         $display("FAIL right_hit2 got=(%0d,%0d) want=(608,192)", ball_x, ball_y);
      end
      ball_speed = 4'd0;
      btns       = 4'b0001;
      tick(10);
      checks++;
      if (paddle1_y !== 9'd0) begin
         failures++;
         $display("FAIL p1_top_sat got=%0d want=0", paddle1_y);
      end
      btns       = 4'b0000;
      ball_speed = 4'd8;
      tick(76);
      checks++;
      if (ball_x !== 10'd0 || ball_y !== 9'd408 || state !== 2'd1) begin
         failures++;
         $display("FAIL reach_left_edge got=(%0d,%0d) st %0d want=(0,408) st 1",
                  ball_x, ball_y, state);
      end
      tick(1);
      checks++;
      if (state !== 2'd2 || score2 !== 4'd0) begin
         failures++;
         $display("FAIL miss_point got=st %0d s2 %0d want=st 2 s2 0", state, score2);
      end
      tick(1);
      checks++;
      if (state !== 2'd0 || score2 !== 4'd1 || score1 !== 4'd0 ||
          ball_x !== 10'd316 || ball_y !== 9'd236) begin
         failures++;
         $display("FAIL point_to_serve got=st %0d s %0d-%0d (%0d,%0d) want=st 0 s 0-1 (316,236)",
                  state, score1, score2, ball_x, ball_y);
      end
      ball_speed = 4'd4;
      tick(60);
      tick(1);
      checks++;
      if (state !== 2'd1 || ball_x !== 10'd312) begin
         failures++;
         $display("FAIL serve_dir_left got=st %0d x %0d want=st 1 x 312", state, ball_x);
      end
   endtask

   task automatic test_win();
      do_reset();
      ball_speed   = 4'd15;
      player_speed = 4'd0;
      btns         = 4'b0000;
      for (int p = 1; p <= 9; p++) begin
         tick(82);
         checks++;
         if (state !== 2'd2) begin
            failures++;
            $display("FAIL right_miss_point pt=%0d got=st %0d want=st 2", p, state);
         end
         tick(1);
         checks++;
         if (score1 !== 4'(p) || score2 !== 4'd0 || state !== ((p == 9) ? 2'd3 : 2'd0)) begin
            failures++;
            $display("FAIL p1_scores pt=%0d got=s %0d-%0d st %0d want=s %0d-0 st %0d",
                     p, score1, score2, state, p, (p == 9) ? 3 : 0);
         end
      end
      checks++;
      if (game_over !== 1'b1) begin
         failures++;
         $display("FAIL game_over_set got=%0d want=1", game_over);
      end
      tick(3);
      checks++;
      if (state !== 2'd3 || score1 !== 4'd9 || game_over !== 1'b1) begin
         failures++;
         $display("FAIL over_hold got=st %0d s1 %0d go %0d want=st 3 s1 9 go 1",
                  state, score1, game_over);
      end
      btns = 4'b0001;
      tick(1);
      checks++;
      if (state !== 2'd0 || score1 !== 4'd0 || score2 !== 4'd0 || game_over !== 1'b0 ||
          paddle1_y !== 9'd208) begin
         failures++;
         $display("FAIL over_restart got=st %0d s %0d-%0d go %0d p1 %0d want=st 0 s 0-0 go 0 p1 208",
                  state, score1, score2, game_over, paddle1_y);
      end
      btns = 4'b0000;
   endtask

   task automatic test_paddles();
      do_reset();
      player_speed = 4'd4;
      ball_speed   = 4'd0;
      btns         = 4'b0011;
      tick(10);
      checks++;
      if (paddle1_y !== 9'd208) begin
         failures++;
         $display("FAIL both_buttons_hold got=%0d want=208", paddle1_y);
      end
      btns = 4'b0001;
      tick(60);
      checks++;
      if (paddle1_y !== 9'd0 || state !== 2'd1) begin
         failures++;
         $display("FAIL p1_up_sat got=p1 %0d st %0d want=p1 0 st 1", paddle1_y, state);
      end
      btns = 4'b1000;
      tick(60);
      checks++;
      if (paddle2_y !== 9'd416) begin
         failures++;
         $display("FAIL p2_down_sat2 got=%0d want=416", paddle2_y);
      end
      btns = 4'b0100;
      repeat (4) @(negedge CLK);
      checks++;
      if (paddle2_y !== 9'd416) begin
         failures++;
         $display("FAIL paddle_no_tick got=%0d want=416", paddle2_y);
      end
      btns = 4'b0000;
      rst  = 1'b1;
      @(negedge CLK);
      checks++;
      if (state !== 2'd0 || ball_x !== 10'd316 || ball_y !== 9'd236 ||
          paddle1_y !== 9'd208 || paddle2_y !== 9'd208 || score1 !== 4'd0 ||
          score2 !== 4'd0 || game_over !== 1'b0) begin
         failures++;
         $display("FAIL mid_play_reset got=st %0d (%0d,%0d) p %0d/%0d s %0d-%0d go %0d want=0 (316,236) 208/208 0-0 0",
                  state, ball_x, ball_y, paddle1_y, paddle2_y, score1, score2, game_over);
      end
      rst = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      frame_tick   = 1'b0;
      btns         = 4'b0000;
      ball_speed   = 4'd0;
      player_speed = 4'd0;
      test_reset();
      test_serve();
      test_wall_bounce();
      test_right_paddle();
      test_left_paddle();
      test_left_miss();
      test_win();
      test_paddles();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
